cm_loader: RTL

Context-memory loader for the CGRA fabric. It takes a stream of 16-bit configuration words from the host over a valid/ready handshake and writes them into consecutive context-memory locations, starting at a host-supplied base address. It is the write side of the context memory and sits beside the fabric's `rd_cm_en`/`cm_addr` read port, sharing the same 6-bit address space.

---
 rtl/cm_loader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cm_loader.sv
// rtl/cm_loader.sv - Context-memory loader: streams host words into consecutive context-memory locations
//
// Purpose:
//   Accepts a load request (base address, word count), then writes each
//   handshaked host word into context memory at an incrementing address.
//   The address wraps modulo DEPTH. IDLE -> LOAD -> DONE -> IDLE.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset      in   asynchronous active-low reset
//   start      in   load request, sampled only in IDLE
//   base_addr  in   first write address, captured on accepted start
//   word_cnt   in   number of words (0..DEPTH valid, larger is rejected)
//   in_valid   in   host word valid
//   in_data    in   host word
//   in_ready   out  loader can accept a word this cycle
//   wr_cm_en   out  context-memory write strobe (registered)
//   cm_addr    out  write address (registered)
//   cm_wdata   out  write data (registered)
//   busy       out  high in LOAD and DONE
//   done       out  one-cycle completion pulse
//   err        out  one-cycle pulse for a rejected start
//   cksum      out  running XOR of written words
//
// Configuration:
//   CM_LOADER_CKSUM_EN - when defined, builds the XOR checksum register;
//                        otherwise cksum is tied to 0.

module cm_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_cnt,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_cm_en,
    output logic [ADDR_W-1:0] cm_addr,
    output logic [DATA_W-1:0] cm_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] cksum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(DEPTH);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   rem_q;
    logic              start_ok;
    logic              start_bad;
    logic              hs;

    assign start_ok  = (state_q == IDLE) && start && (word_cnt <= MAX_CNT);
    assign start_bad = (state_q == IDLE) && start && (word_cnt > MAX_CNT);
    assign hs        = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A zero-length request passes through LOAD with
    // remaining already 0, which places the done pulse one cycle after
    // the accepting edge, matching the timing of a normal load's tail.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = LOAD;
            LOAD: if (rem_q == '0) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state (in_ready never looks at in_valid)
    always_comb begin
        in_ready = (state_q == LOAD) && (rem_q != '0);
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
    end

    // Pointer, remaining counter and registered write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q    <= '0;
            rem_q    <= '0;
            wr_cm_en <= 1'b0;
            cm_addr  <= '0;
            cm_wdata <= '0;
            err      <= 1'b0;
        end else begin
            wr_cm_en <= hs;
            err      <= start_bad;
            if (start_ok) begin
                ptr_q <= base_addr;
                rem_q <= word_cnt;
            end else if (hs) begin
                cm_addr  <= ptr_q;
                cm_wdata <= in_data;
                // Natural ADDR_W-bit overflow gives the modulo-DEPTH wrap
                ptr_q    <= ptr_q + ADDR_W'(1);
                rem_q    <= rem_q - (ADDR_W+1)'(1);
            end
        end
    end

`ifdef CM_LOADER_CKSUM_EN
    logic [DATA_W-1:0] cksum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cksum_q <= '0;
        end else if (start_ok) begin
            cksum_q <= '0;
        end else if (hs) begin
            cksum_q <= cksum_q ^ in_data;
        end
    end

    assign cksum = cksum_q;
`else
    assign cksum = '0;
`endif

endmodule
